// File: rtl/gpr_file_pkg.sv
// Shared integer register file parameters and register-index types.
// Reused by decode, writeback select and the register file itself.
package gpr_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage : gpr_file_pkg

// File: rtl/gpr_file_scoreboard.sv
// Per-register busy bits for long-latency producers, with same-cycle
// clear bypass on the two lookup ports. Index 0 is never busy.
module gpr_scoreboard
    import gpr_file_pkg::*;
#(
    parameter int ADDR_W = gpr_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              mark_busy,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

    logic [NREG-1:0] busy_q;

    // The set is ordered after the clear so a new producer issued on the
    // same edge as an older one's writeback keeps the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            if (we && (waddr != ZERO_IDX))
                busy_q[waddr] <= 1'b0;
            if (mark_busy && (mark_addr != ZERO_IDX))
                busy_q[mark_addr] <= 1'b1;
        end
    end

    always_comb begin
        busy1 = (raddr1 != ZERO_IDX) && busy_q[raddr1] && !(we && (waddr == raddr1));
        busy2 = (raddr2 != ZERO_IDX) && busy_q[raddr2] && !(we && (waddr == raddr2));
    end

endmodule : gpr_scoreboard

// File: rtl/gpr_file.sv
// Integer register file: two combinational read ports with write-through
// bypass, hard-wired zero register, and busy scoreboard driving decode stall.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_W = gpr_file_pkg::DATA_W,
    parameter int ADDR_W = gpr_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mark_busy,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic              re1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (we && (waddr != ZERO_IDX)) begin
            regs[waddr] <= wdata;
        end
    end

    // Zero index wins over bypass so a discarded write to x0 never leaks.
    always_comb begin
        if (raddr1 == ZERO_IDX)
            rdata1 = '0;
        else if (we && (waddr == raddr1))
            rdata1 = wdata;
        else
            rdata1 = regs[raddr1];

        if (raddr2 == ZERO_IDX)
            rdata2 = '0;
        else if (we && (waddr == raddr2))
            rdata2 = wdata;
        else
            rdata2 = regs[raddr2];
    end

    gpr_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .mark_busy (mark_busy),
        .mark_addr (mark_addr),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    // A port decode does not use can never hold the pipeline.
    assign stall = (re1 && busy1) || (re2 && busy2);

endmodule : gpr_file
